multdiv_unit: RTL and testbench
===============================

// Module: multdiv_unit
// PURPOSE
//  Multi-cycle signed 32-bit multiply/divide unit; completes the operations the single-cycle alu does not.
//  Responder to a one-cycle command pulse from the pipeline's execute stage.
//  Operands are latched on the pulse; the result comes back with a one-cycle ready strobe and an exception flag.
//  Sits beside alu in execute; the stall logic holds the pipeline from pulse until data_resultRDY.
// PARAMETERS
//  WIDTH   32   operand/result width; the iteration count equals WIDTH
// PORTS
//  clock           in   1      single clock; all state updates on posedge
//  reset           in   1      synchronous, active-high
//  data_operandA   in   WIDTH  multiplicand / dividend, two's complement
//  data_operandB   in   WIDTH  multiplier / divisor, two's complement
//  ctrl_MULT       in   1      one-cycle start pulse: A*B
//  ctrl_DIV        in   1      one-cycle start pulse: A/B
//  data_result     out  WIDTH  low WIDTH bits of product, or quotient
//  data_exception  out  1      multiply overflow or divide-by-zero; valid with RDY
//  data_resultRDY  out  1      one-cycle strobe; result/exception valid
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: state=IDLE, count=0, data_result=0, data_exception=0, data_resultRDY=0.
//    Reset overrides any ctrl pulse in the same cycle.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: on edge E0 with ctrl_MULT|ctrl_DIV, latch |A|, |B|, result sign, op and count=0 -> BUSY.
//    BUSY: edges E1..E32 each perform one iteration, count++.
//      MUL: shift-add on magnitudes into a 64-bit accumulator.
//      DIV: restoring step, 64-bit remainder/quotient register.
//    E32: apply the sign fix, register result and exception, go to DONE.
//      data_resultRDY=1 for exactly the cycle between E32 and E33.
//    DONE: RDY drops at E33 -> IDLE.
//    data_result and data_exception hold until the next operation completes or reset.
//  Latency: fixed 32 cycles from the capture edge to the RDY cycle, for every operand value including B=0.
//  Arithmetic:
//    MUL exception=1 iff the 64-bit signed product is not equal to the sign extension of its low 32 bits.
//      data_result is always the low 32 bits.
//    DIV quotient truncates toward zero; the remainder is discarded.
//    DIV with B==0: exception=1, data_result=0.
//    DIV 0x80000000 / 0xFFFFFFFF: exception=1, data_result=0x80000000.
//  Boundary conditions:
//    ctrl_MULT and ctrl_DIV both high: treated as MULT.
//    New ctrl pulse while BUSY or DONE: the current op is aborted; new operands latched, count=0, restart BUSY.
//      No RDY is issued for the aborted op; a pulse in the DONE cycle still lets that RDY complete.
//    Operand changes after the capture edge are ignored.
//    Reset mid-BUSY: return to IDLE with outputs 0 at the next edge; no RDY.
// STRUCTURE
//  Shared package multdiv_pkg:
//    state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
//    op constants (OP_MUL=1'b0, OP_DIV=1'b1)
//    MD_ITER=32
//  One sub-module, multdiv_counter: 6-bit synchronous counter with clear and enable; terminal flag at 32.
//  Datapath (accumulators, sign fix, exception detect) stays in multdiv_unit.
// TESTING
//  Latency:
//    MUL A=3, B=-4 pulsed at E0.
//    -> RDY only in the cycle after E32, result=0xFFFFFFF4, exc=0.
//  MUL overflow:
//    A=0x00010000, B=0x00010000 -> exc=1, result=0x00000000.
//    A=0x7FFFFFFF, B=1 -> exc=0, result=0x7FFFFFFF.
//  DIV:
//    A=-7, B=2 -> result=0xFFFFFFFD, exc=0.
//    A=7, B=0 -> exc=1, result=0, same 32-cycle latency.
//    A=0x80000000, B=-1 -> exc=1, result=0x80000000.
//  Abort:
//    DIV 100/5 started, then MUL 6*7 pulsed 10 cycles later.
//    -> exactly one RDY, 32 cycles after the second pulse, result=42.
//  Reset mid-op:
//    Assert reset 15 cycles into a MUL.
//    -> outputs 0 next edge, no RDY.
//    -> a fresh DIV 9/3 then returns 3.
//  Simultaneous ctrl: ctrl_MULT=ctrl_DIV=1, A=6, B=3 -> result=18 (MUL wins).

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants and types for the multi-cycle multiply/divide unit.
package multdiv_pkg;

  localparam int MD_ITER = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide unit: 6-bit, synchronous clear and enable.
// o_last flags the enabled step that takes the count to LAST (the final iteration).
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int LAST = MD_ITER
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);

  logic [5:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_count <= 6'd0;
    end else if (i_en) begin
      r_count <= r_count + 6'd1;
    end
  end

  assign o_last = i_en && (r_count == 6'(LAST - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Signed multiply/divide over magnitudes: 32 shift-add or restoring steps, then a sign fix.
// Fixed latency of WIDTH cycles from capture to a one-cycle ready strobe; a new pulse aborts.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  md_state_t          r_state;
  logic               r_op;
  logic               r_neg;
  logic               r_bzero;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_rq;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;
  logic               r_rdy;

  logic               w_start;
  logic               w_op;
  logic               w_last;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_shl;
  logic [2*WIDTH-1:0] w_rq_nxt;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_fin_result;
  logic               w_fin_exc;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_op    = ctrl_MULT ? OP_MUL : OP_DIV;
  assign w_mag_a = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
  assign w_mag_b = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;

  multdiv_counter #(.LAST(WIDTH)) u_counter (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_start),
    .i_en   (r_state == ST_BUSY),
    .o_last (w_last)
  );

  // r_rq is {product_hi, multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    w_sum        = {1'b0, r_rq[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_shl        = {r_rq[2*WIDTH-2:0], 1'b0};
    w_diff       = {1'b0, w_shl[2*WIDTH-1:WIDTH]} - {1'b0, r_opnd};
    w_rq_nxt     = r_rq;
    w_prod_s     = '0;
    w_quo        = '0;
    w_fin_result = '0;
    w_fin_exc    = 1'b0;
    if (r_op == OP_MUL) begin
      w_rq_nxt     = r_rq[0] ? {w_sum, r_rq[WIDTH-1:1]} : {1'b0, r_rq[2*WIDTH-1:1]};
      w_prod_s     = r_neg ? ('0 - w_rq_nxt) : w_rq_nxt;
      w_fin_result = w_prod_s[WIDTH-1:0];
      w_fin_exc    = (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});
    end else begin
      w_rq_nxt     = w_diff[WIDTH] ? w_shl : {w_diff[WIDTH-1:0], w_shl[WIDTH-1:1], 1'b1};
      w_quo        = w_rq_nxt[WIDTH-1:0];
      // A positive quotient with the top bit set only arises from MIN / -1.
      w_fin_exc    = r_bzero || (!r_neg && w_quo[WIDTH-1]);
      w_fin_result = r_bzero ? '0 : (r_neg ? ('0 - w_quo) : w_quo);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_MUL;
      r_neg    <= 1'b0;
      r_bzero  <= 1'b0;
      r_opnd   <= '0;
      r_rq     <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_state <= ST_BUSY;
        r_op    <= w_op;
        r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_bzero <= (data_operandB == '0);
        r_opnd  <= (w_op == OP_MUL) ? w_mag_a : w_mag_b;
        r_rq    <= {{WIDTH{1'b0}}, ((w_op == OP_MUL) ? w_mag_b : w_mag_a)};
      end else begin
        case (r_state)
          ST_BUSY: begin
            r_rq <= w_rq_nxt;
            if (w_last) begin
              r_result <= w_fin_result;
              r_exc    <= w_fin_exc;
              r_rdy    <= 1'b1;
              r_state  <= ST_DONE;
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed checks of multdiv_unit: latency, arithmetic, exceptions, abort, reset and ctrl priority.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Drive a pulse across one posedge (E0), then scramble operands to prove they were latched.
  task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
  endtask

  // Edges counted from E0 until RDY is seen; -1 if it never comes within the bound.
  task automatic wait_rdy(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        cyc = i;
        return;
      end
    end
    cyc = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs got res=%h exc=%b rdy=%b want 0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    reset = 1'b0;
  endtask

  task automatic test_latency;
    int cyc;
    pulse(1'b1, 1'b0, 32'd3, -32'sd4);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32) begin errors++; $display("FAIL mul_latency got %0d want 32", cyc); end
    checks++;
    if (data_result !== 32'hFFFF_FFF4 || data_exception !== 1'b0) begin
      errors++; $display("FAIL mul_3x-4 got res=%h exc=%b want fffffff4/0", data_result, data_exception);
    end
    @(negedge clock);
    checks++;
    if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL rdy_one_cycle got %b want 0", data_resultRDY); end
    repeat (3) @(negedge clock);
    checks++;
    if (data_result !== 32'hFFFF_FFF4) begin
      errors++; $display("FAIL result_hold got %h want fffffff4", data_result);
    end
  endtask

  task automatic test_mul_overflow;
    int cyc;
    pulse(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32 || data_result !== 32'h0 || data_exception !== 1'b1) begin
      errors++; $display("FAIL mul_ovf cyc=%0d res=%h exc=%b want 32/00000000/1", cyc, data_result, data_exception);
    end
    pulse(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32 || data_result !== 32'h7FFF_FFFF || data_exception !== 1'b0) begin
      errors++; $display("FAIL mul_max cyc=%0d res=%h exc=%b want 32/7fffffff/0", cyc, data_result, data_exception);
    end
  endtask

  task automatic test_div;
    int cyc;
    pulse(1'b0, 1'b1, -32'sd7, 32'd2);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32 || data_result !== 32'hFFFF_FFFD || data_exception !== 1'b0) begin
      errors++; $display("FAIL div_-7/2 cyc=%0d res=%h exc=%b want 32/fffffffd/0", cyc, data_result, data_exception);
    end
    pulse(1'b0, 1'b1, 32'd7, 32'd0);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32 || data_result !== 32'h0 || data_exception !== 1'b1) begin
      errors++; $display("FAIL div_by_zero cyc=%0d res=%h exc=%b want 32/00000000/1", cyc, data_result, data_exception);
    end
    pulse(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32 || data_result !== 32'h8000_0000 || data_exception !== 1'b1) begin
      errors++; $display("FAIL div_min/-1 cyc=%0d res=%h exc=%b want 32/80000000/1", cyc, data_result, data_exception);
    end
    pulse(1'b0, 1'b1, 32'd100, -32'sd7);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32 || data_result !== 32'hFFFF_FFF2 || data_exception !== 1'b0) begin
      errors++; $display("FAIL div_100/-7 cyc=%0d res=%h exc=%b want 32/fffffff2/0", cyc, data_result, data_exception);
    end
  endtask

  task automatic test_abort;
    int cyc;
    pulse(1'b0, 1'b1, 32'd100, 32'd5);
    repeat (9) @(posedge clock);
    pulse(1'b1, 1'b0, 32'd6, 32'd7);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32) begin errors++; $display("FAIL abort_latency got %0d want 32", cyc); end
    checks++;
    if (data_result !== 32'd42 || data_exception !== 1'b0) begin
      errors++; $display("FAIL abort_result got res=%h exc=%b want 0000002a/0", data_result, data_exception);
    end
    @(negedge clock);
    checks++;
    if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL abort_single_rdy got %b want 0", data_resultRDY); end
  endtask

  task automatic test_reset_mid_op;
    int cyc;
    int seen;
    pulse(1'b1, 1'b0, 32'd5, 32'd5);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
      errors++; $display("FAIL reset_mid_outputs got res=%h exc=%b rdy=%b want 0/0/0",
                         data_result, data_exception, data_resultRDY);
    end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_rdy got %0d strobes want 0", seen); end
    pulse(1'b0, 1'b1, 32'd9, 32'd3);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32 || data_result !== 32'd3 || data_exception !== 1'b0) begin
      errors++; $display("FAIL div_9/3 cyc=%0d res=%h exc=%b want 32/00000003/0", cyc, data_result, data_exception);
    end
  endtask

  task automatic test_simultaneous;
    int cyc;
    pulse(1'b1, 1'b1, 32'd6, 32'd3);
    wait_rdy(cyc);
    checks++;
    if (cyc !== 32 || data_result !== 32'd18 || data_exception !== 1'b0) begin
      errors++; $display("FAIL both_ctrl cyc=%0d res=%h exc=%b want 32/00000012/0", cyc, data_result, data_exception);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mul_overflow();
    test_div();
    test_abort();
    test_reset_mid_op();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
